alu_share_arbiter: RTL and testbench

- Shares one ALU instance between NUM_REQ requesters, e.g. the integer pipe and the branch/address-generation unit in the 5-stage core.
- Round-robin arbitration with a valid/ready handshake per requester.
- A single registered response slot returns the result tagged with the winner's ID.
- Sits between the execute-stage requesters and the combinational ALU.

---
 rtl/alu_share_arbiter_pkg.sv | 26 ++
 rtl/alu.sv | 29 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 37 +++
 rtl/alu_share_arbiter.sv | 95 +++++++++
 tb/tb_alu_share_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcode constants and types for the ALU share arbiter.
// Imported by the arbiter, its round-robin picker and the ALU.
package alu_share_arbiter_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int RSP_DATA_W = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU of the core.
// Unknown opcodes yield zero.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op,
  input  logic [RSP_DATA_W-1:0] a,
  input  logic [RSP_DATA_W-1:0] b,
  output logic [RSP_DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, with wrap.
// Produces a one-hot grant and its binary index (0 when idle).
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[k] && ID_W'(k) >= ptr) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
    // wrap-around pass below the pointer
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[k] && ID_W'(k) < ptr) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters, round-robin,
// with a single registered response slot tagged by winner ID.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_op_a_i,
  input  logic [NUM_REQ*32-1:0]   req_op_b_i,
  input  logic [NUM_REQ*4-1:0]    req_alu_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [RSP_DATA_W-1:0]   rsp_data_o
);

  slot_state_e state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  can_accept;
  logic                  fire;
  logic [RSP_DATA_W-1:0] op_a, op_b, alu_y;
  logic [ALU_OP_W-1:0]   alu_op;

  assign can_accept = !rst_i &&
    (state == SLOT_EMPTY || rsp_ready_i);
  assign fire = |gnt;
  assign req_ready_o = gnt;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // idle grant index is 0, so the mux falls back to requester 0
  always_comb begin
    op_a   = req_op_a_i[31:0];
    op_b   = req_op_b_i[31:0];
    alu_op = req_alu_op_i[3:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == gnt_idx) begin
        op_a   = req_op_a_i[32*k +: 32];
        op_b   = req_op_b_i[32*k +: 32];
        alu_op = req_alu_op_i[4*k +: 4];
      end
    end
  end

  alu u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= SLOT_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fire)
      state_nxt = SLOT_FULL;
    else if (state == SLOT_FULL && rsp_ready_i)
      state_nxt = SLOT_EMPTY;
  end

  always_comb begin
    rsp_valid_o = (state == SLOT_FULL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_o <= '0;
      rsp_id_o   <= '0;
      rr_ptr     <= '0;
    end else if (fire) begin
      rsp_data_o <= alu_y;
      rsp_id_o   <= gnt_idx;
      rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ-1)) ?
                    '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed results.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] op_a, op_b;
  logic [7:0]  alu_op;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_a_i   (op_a),
    .req_op_b_i   (op_b),
    .req_alu_op_i (alu_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b,
                      input alu_op_e op);
    op_a[31:0]  = a;
    op_b[31:0]  = b;
    alu_op[3:0] = op;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b,
                      input alu_op_e op);
    op_a[63:32] = a;
    op_b[63:32] = b;
    alu_op[7:4] = op;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    alu_op = '0;
    #2;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id", {30'b0, rsp_id}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_ptr", {30'b0, dut.rr_ptr}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // single request
    set0(32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", {30'b0, req_ready}, 32'd1);
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("single_valid", {31'b0, rsp_valid}, 32'd1);
    chk("single_id", {30'b0, rsp_id}, 32'd0);
    chk("single_data", rsp_data, 32'd12);
    next_cycle();
    #1;
    chk("drain_valid", {31'b0, rsp_valid}, 32'd0);
    chk("ptr_idle", {30'b0, dut.rr_ptr}, 32'd1);

    // reset pulse returns the pointer to requester 0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // contention fairness
    set0(32'd10, 32'd3, ALU_SUB);
    set1(32'hF0, 32'h0F, ALU_XOR);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 4) ? 2'b11 : 2'b00;
      #1;
      if (i < 4)
        chk($sformatf("rr_ready%0d", i), {30'b0, req_ready},
            (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        chk($sformatf("rr_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("rr_id%0d", i), {30'b0, rsp_id},
            ((i - 1) % 2 == 0) ? 32'd0 : 32'd1);
        chk($sformatf("rr_data%0d", i), rsp_data,
            ((i - 1) % 2 == 0) ? 32'd7 : 32'hFF);
      end
      next_cycle();
    end

    // backpressure
    set0(32'd5, 32'd7, ALU_ADD);
    set1(32'h30, 32'h03, ALU_OR);
    req_valid = 2'b01;
    #1;
    chk("bp_fill_ready", {30'b0, req_ready}, 32'd1);
    next_cycle();
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), {30'b0, req_ready}, 32'd0);
      chk($sformatf("bp_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("bp_data%0d", i), rsp_data, 32'd12);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'b0, req_ready}, 32'd2);
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("bp_rsp_id", {30'b0, rsp_id}, 32'd1);
    chk("bp_rsp_data", rsp_data, 32'h33);
    next_cycle();

    // back-to-back SLT then SLTU
    set0(32'hFFFF_FFFF, 32'd1, ALU_SLT);
    req_valid = 2'b01;
    #1;
    chk("b2b_ready0", {30'b0, req_ready}, 32'd1);
    next_cycle();
    set0(32'hFFFF_FFFF, 32'd1, ALU_SLTU);
    #1;
    chk("b2b_ready1", {30'b0, req_ready}, 32'd1);
    chk("b2b_valid0", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_slt", rsp_data, 32'd1);
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("b2b_valid1", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_sltu", rsp_data, 32'd0);
    next_cycle();
    #1;
    chk("b2b_drain", {31'b0, rsp_valid}, 32'd0);

    // async reset while FULL
    set0(32'd1, 32'd1, ALU_ADD);
    req_valid = 2'b01;
    next_cycle();
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    set1(32'h8000_0000, 32'd4, ALU_SRA);
    #1;
    chk("ar_full", {31'b0, rsp_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, rsp_valid}, 32'd0);
    chk("ar_ptr", {30'b0, dut.rr_ptr}, 32'd0);
    chk("ar_ready", {30'b0, req_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("ar_grant", {30'b0, req_ready}, 32'd2);
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("ar_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("ar_rsp_id", {30'b0, rsp_id}, 32'd1);
    chk("ar_rsp_data", rsp_data, 32'hF800_0000);

    // unknown opcode yields zero
    next_cycle();
    op_a[31:0]  = 32'd9;
    op_b[31:0]  = 32'd9;
    alu_op[3:0] = 4'hF;
    req_valid = 2'b01;
    next_cycle();
    req_valid = 2'b00;
    #1;
    chk("unk_op", rsp_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
